// File: rtl/seq1101_pkg.sv
// Shared encodings for the 1101 stream controller and its serial detector.
package seq1101_pkg;

  // Detector states, named by the prefix of the pattern seen so far.
  typedef enum logic [2:0] {
    DET_S0    = 3'd0,
    DET_S1    = 3'd1,
    DET_S11   = 3'd2,
    DET_S110  = 3'd3,
    DET_S1101 = 3'd4
  } det_state_t;

  // Word-level sequencing states of the controller.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } ctrl_state_t;

  // Serial pattern recognised by the detector, first bit in the MSB.
  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq1101_moore_core.sv
// Overlapping Moore recogniser for the serial pattern 1101.
//
// state     | meaning
// ----------+------------------------------------------------
// DET_S0    | no useful prefix seen
// DET_S1    | last bit was 1
// DET_S11   | last bits were 11
// DET_S110  | last bits were 110
// DET_S1101 | pattern just completed, dout=1
module seq1101_moore_core
  import seq1101_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic       dout,
  output det_state_t state
);

  det_state_t state_q;
  det_state_t state_d;

  // Next state: clear wins over advance; otherwise hold unless enabled.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_S0;
    end else if (en) begin
      case (state_q)
        DET_S0:    state_d = (din == PATTERN[3]) ? DET_S1    : DET_S0;
        DET_S1:    state_d = (din == PATTERN[2]) ? DET_S11   : DET_S0;
        // A third '1' still leaves "11" as a valid prefix.
        DET_S11:   state_d = (din == PATTERN[1]) ? DET_S110  : DET_S11;
        DET_S110:  state_d = (din == PATTERN[0]) ? DET_S1101 : DET_S0;
        // Overlap: the trailing '1' of a match can start the next one.
        DET_S1101: state_d = din ? DET_S11 : DET_S0;
        default:   state_d = DET_S0;
      endcase
    end
  end

  // Detector state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DET_S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign dout  = (state_q == DET_S1101);
  assign state = state_q;

endmodule

// File: rtl/seq1101_stream_ctrl.sv
// Word-oriented wrapper that feeds words MSB-first into the 1101 detector
// and reports a per-word match count and match-position mask.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a word; in_ready high
// ST_SHIFT  | presenting one word bit per cycle, sampling previous bit
// ST_DRAIN  | one cycle to sample the match for the last bit
// ST_REPORT | result held on out_* until the consumer takes it
module seq1101_stream_ctrl
  import seq1101_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              keep_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [WORD_W-1:0] out_mask,
  output logic              out_hit
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  ctrl_state_t        state_q;
  ctrl_state_t        state_d;
  logic               in_ready_q;
  logic [WORD_W-1:0]  shreg_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   count_q;
  logic [WORD_W-1:0]  mask_q;

  logic               accept;
  logic               det_clr;
  logic               det_en;
  logic               det_din;
  logic               det_dout;
  det_state_t         det_state;
  logic               sample;
  logic [IDX_W-1:0]   sample_pos;
  logic [WORD_W-1:0]  sample_bit;

  // The detector state is exported for debug visibility only.
  logic               unused_det_state;
  assign unused_det_state = ^det_state;

  assign accept  = (state_q == ST_IDLE) && in_ready_q && in_valid;
  assign det_clr = accept && !keep_state;
  assign det_en  = (state_q == ST_SHIFT);
  assign det_din = shreg_q[WORD_W-1];

  // The detector output lags its input by one cycle, so the bit judged now
  // was presented last cycle: in_data[WORD_W-idx] in SHIFT, in_data[0] in
  // DRAIN. The modular subtraction stays in range because idx >= 1 here.
  assign sample     = ((state_q == ST_SHIFT) && (idx_q != '0)) ||
                      (state_q == ST_DRAIN);
  assign sample_pos = (state_q == ST_DRAIN) ? '0 : (IDX_W'(WORD_W) - idx_q);
  assign sample_bit = WORD_W'(1) << sample_pos;

  seq1101_moore_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr),
    .en    (det_en),
    .din   (det_din),
    .dout  (det_dout),
    .state (det_state)
  );

  // Controller next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept)            state_d = ST_SHIFT;
      ST_SHIFT:  if (idx_q == IDX_LAST) state_d = ST_DRAIN;
      ST_DRAIN:                         state_d = ST_REPORT;
      ST_REPORT: if (out_ready)         state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // State register; in_ready is registered so it stays low through reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_IDLE);
    end
  end

  // Word shifter and bit index: load on accept, advance one bit per SHIFT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (accept) begin
      shreg_q <= in_data;
      idx_q   <= '0;
    end else if (state_q == ST_SHIFT) begin
      shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
      idx_q   <= idx_q + 1'b1;
    end
  end

  // Result accumulation: cleared on accept, updated from the lagged match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      mask_q  <= '0;
    end else if (accept) begin
      count_q <= '0;
      mask_q  <= '0;
    end else if (sample && det_dout) begin
      mask_q <= mask_q | sample_bit;
      if (count_q != CNT_MAX) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == ST_REPORT);
  assign out_count = count_q;
  assign out_mask  = mask_q;
  assign out_hit   = |mask_q;

endmodule

// File: tb/tb_seq1101_stream_ctrl.sv
// Self-checking bench for seq1101_stream_ctrl with a pattern-window model.
module tb_seq1101_stream_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          keep_state;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;
  logic [W-1:0]  out_mask;
  logic          out_hit;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: last four bits seen since the last clear.
  int m_hist;
  int m_nbits;
  int last_acc;
  bit chain_ok;

  seq1101_stream_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .keep_state (keep_state),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_mask   (out_mask),
    .out_hit    (out_hit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A match completes on a bit when the last four bits since clear are 1101.
  task automatic model_word(input logic [W-1:0] d, input bit keep,
                            output int cnt, output logic [W-1:0] mask);
    if (!keep) begin
      m_hist  = 0;
      m_nbits = 0;
    end
    cnt  = 0;
    mask = '0;
    for (int k = W - 1; k >= 0; k--) begin
      m_hist = ((m_hist << 1) | int'(d[k])) & 15;
      if (m_nbits < 4) m_nbits++;
      if (m_nbits >= 4 && m_hist == 13) begin
        mask[k] = 1'b1;
        if (cnt < (1 << CW) - 1) cnt++;
      end
    end
  endtask

  task automatic run_word(input logic [W-1:0] d, input bit keep, input int delay,
                          input bit use_const, input int c_cnt, input logic [W-1:0] c_mask);
    int j;
    int acc;
    int exp_cnt;
    logic [W-1:0] exp_mask;
    j = 0;
    while (!in_ready && j < 40) begin
      @(negedge clk);
      j++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid   = 1'b1;
    in_data    = d;
    keep_state = keep;
    @(negedge clk);
    acc = cyc;
    model_word(d, keep, exp_cnt, exp_mask);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    if (chain_ok) check("accept_spacing", 32'(acc - last_acc), 32'(W + 3));
    last_acc = acc;
    j = 0;
    while (!out_valid && j < 40) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = W'($urandom);
      keep_state = 1'($urandom_range(0, 1));
      @(negedge clk);
      j++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      chain_ok = 1'b0;
      return;
    end
    check("latency", 32'(j + 1), 32'(W + 2));
    check("count", 32'(out_count), 32'(exp_cnt));
    check("mask", 32'(out_mask), 32'(exp_mask));
    check("hit", 32'(out_hit), 32'(|exp_mask));
    check("report_in_ready", 32'(in_ready), 32'd0);
    if (use_const) begin
      check("count_const", 32'(out_count), 32'(c_cnt));
      check("mask_const", 32'(out_mask), 32'(c_mask));
    end
    for (int i = 0; i < delay; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_count", 32'(out_count), 32'(exp_cnt));
      check("hold_mask", 32'(out_mask), 32'(exp_mask));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("released_valid", 32'(out_valid), 32'd0);
    check("ready_after_hs", 32'(in_ready), 32'd1);
    chain_ok = (delay == 0);
  endtask

  initial begin
    int d;
    int k;
    int dl;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    keep_state = 1'b0;
    out_ready  = 1'b0;
    chain_ok   = 1'b0;
    m_hist     = 0;
    m_nbits    = 0;
    last_acc   = 0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_mask", 32'(out_mask), 32'd0);
    check("rst_hit", 32'(out_hit), 32'd0);
    reset = 1'b1;
    #1;
    check("rel_in_ready_early", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_count", 32'(out_count), 32'd0);
    check("rel_mask", 32'(out_mask), 32'd0);

    run_word(8'hDD, 1'b0, 0, 1'b1, 2, 8'h11);
    run_word(8'hDB, 1'b0, 0, 1'b1, 2, 8'h12);
    run_word(8'h06, 1'b0, 0, 1'b1, 0, 8'h00);
    run_word(8'h80, 1'b1, 0, 1'b1, 1, 8'h80);
    run_word(8'h06, 1'b0, 0, 1'b1, 0, 8'h00);
    run_word(8'h80, 1'b0, 0, 1'b1, 0, 8'h00);
    run_word(8'hDD, 1'b0, 5, 1'b1, 2, 8'h11);
    run_word(8'h00, 1'b0, 0, 1'b1, 0, 8'h00);
    run_word(8'hFF, 1'b0, 0, 1'b1, 0, 8'h00);

    // Abort a word with reset partway through SHIFT.
    in_valid   = 1'b1;
    in_data    = 8'hDD;
    keep_state = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("mid_rst_count", 32'(out_count), 32'd0);
    check("mid_rst_mask", 32'(out_mask), 32'd0);
    reset    = 1'b1;
    m_hist   = 0;
    m_nbits  = 0;
    chain_ok = 1'b0;
    #1;
    check("mid_rel_in_ready_early", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    check("mid_rel_hit", 32'(out_hit), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("no_stale_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    run_word(8'h0D, 1'b1, 0, 1'b1, 1, 8'h01);

    for (int n = 0; n < 1000; n++) begin
      d  = int'($urandom_range(0, 255));
      k  = int'($urandom_range(0, 1));
      dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_word(W'(d), k[0], dl, 1'b0, 0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
